// File: rtl/seed_bit_pack.sv
// Seed descriptor packer: aligns seed-address valids with frame-memory pixel returns, compares each
// sample against the keypoint centre and packs the bits LSB-first into DW-bit words behind a 2-entry FIFO.
//
// state | meaning
// IDLE  | waiting for sample 0 of a keypoint
// ACC   | accumulating samples 1..NUM_SEED-1
module seed_bit_pack #(
    parameter int               NUM_SEED = 249,
    parameter int               DW       = 32,
    parameter int               PIX_W    = 8,
    parameter int               MEM_LAT  = 2,
    parameter logic [PIX_W-1:0] THR      = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_addr1,
    input  logic             valid_addr2,
    input  logic             valid_addr3,
    input  logic             valid_addr4,
    input  logic [PIX_W-1:0] pix_in,
    input  logic [PIX_W-1:0] center_pix,
    output logic [DW-1:0]    desc_data,
    output logic             desc_last,
    output logic [23:0]      desc_meta,
    output logic             desc_valid,
    input  logic             desc_ready,
    output logic             kp_done,
    output logic             overflow
);

    localparam int SW = $clog2(NUM_SEED);
    localparam int PW = $clog2(DW);

    typedef enum logic [0:0] {IDLE, ACC} state_t;

    state_t            state;
    logic [MEM_LAT-1:0] dl1, dl2, dl3, dl4;
    logic              d1, d2, d3, d4;
    logic [SW-1:0]     seed_idx;
    logic [PW-1:0]     pos;
    logic [DW-1:0]     shreg;
    logic [PIX_W-1:0]  ref_pix;
    logic [7:0]        cnt2, cnt3, cnt4;

    // Valids ride a MEM_LAT-deep pipe so they meet the pixel coming back from memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dl1 <= '0;
            dl2 <= '0;
            dl3 <= '0;
            dl4 <= '0;
        end else begin
            dl1[0] <= valid_addr1;
            dl2[0] <= valid_addr2;
            dl3[0] <= valid_addr3;
            dl4[0] <= valid_addr4;
            for (int i = 1; i < MEM_LAT; i++) begin
                dl1[i] <= dl1[i-1];
                dl2[i] <= dl2[i-1];
                dl3[i] <= dl3[i-1];
                dl4[i] <= dl4[i-1];
            end
        end
    end

    assign d1 = dl1[MEM_LAT-1];
    assign d2 = dl2[MEM_LAT-1];
    assign d3 = dl3[MEM_LAT-1];
    assign d4 = dl4[MEM_LAT-1];

    logic [PIX_W-1:0] ref_cmp;
    logic [PIX_W:0]   ref_thr;
    logic             bit_s;
    logic             last_s;
    logic             word_end;
    logic             push;
    logic [DW-1:0]    word_next;
    logic [7:0]       cnt2_n, cnt3_n, cnt4_n;
    logic [23:0]      push_meta;

    // Sample 0 compares against the live centre pixel, later samples against the latched copy.
    assign ref_cmp   = (seed_idx == '0) ? center_pix : ref_pix;
    assign ref_thr   = {1'b0, ref_cmp} + {1'b0, THR};
    assign bit_s     = {1'b0, pix_in} > ref_thr;
    assign last_s    = (seed_idx == SW'(NUM_SEED - 1));
    assign word_end  = (pos == PW'(DW - 1));
    assign push      = d1 & (word_end | last_s);
    assign word_next = shreg | (DW'(bit_s) << pos);

    assign cnt2_n    = (d2 && cnt2 != 8'hFF) ? cnt2 + 8'd1 : cnt2;
    assign cnt3_n    = (d3 && cnt3 != 8'hFF) ? cnt3 + 8'd1 : cnt3;
    assign cnt4_n    = (d4 && cnt4 != 8'hFF) ? cnt4 + 8'd1 : cnt4;
    assign push_meta = last_s ? {cnt4_n, cnt3_n, cnt2_n} : 24'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            seed_idx <= '0;
            pos      <= '0;
            shreg    <= '0;
            ref_pix  <= '0;
            cnt2     <= '0;
            cnt3     <= '0;
            cnt4     <= '0;
            kp_done  <= 1'b0;
        end else begin
            kp_done <= d1 & last_s;
            if (d1) begin
                case (state)
                    IDLE:    state <= last_s ? IDLE : ACC;
                    ACC:     state <= last_s ? IDLE : ACC;
                    default: state <= IDLE;
                endcase
                if (seed_idx == '0)
                    ref_pix <= center_pix;
                if (last_s) begin
                    seed_idx <= '0;
                    pos      <= '0;
                    shreg    <= '0;
                    cnt2     <= '0;
                    cnt3     <= '0;
                    cnt4     <= '0;
                end else begin
                    seed_idx <= seed_idx + SW'(1);
                    pos      <= word_end ? '0 : pos + PW'(1);
                    shreg    <= word_end ? '0 : word_next;
                    cnt2     <= cnt2_n;
                    cnt3     <= cnt3_n;
                    cnt4     <= cnt4_n;
                end
            end
        end
    end

    logic [DW-1:0] fifo_data [2];
    logic          fifo_last [2];
    logic [23:0]   fifo_meta [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    fifo_cnt;
    logic          pop, full, do_write;

    assign full     = (fifo_cnt == 2'd2);
    assign pop      = (fifo_cnt != 2'd0) & desc_ready;
    // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
    assign do_write = push & (~full | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
                fifo_meta[i] <= '0;
            end
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write) begin
                fifo_data[wr_ptr] <= word_next;
                fifo_last[wr_ptr] <= last_s;
                fifo_meta[wr_ptr] <= push_meta;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, do_write} - {1'b0, pop};
            if (push & full & ~pop)
                overflow <= 1'b1;
        end
    end

    assign desc_valid = (fifo_cnt != 2'd0);
    assign desc_data  = desc_valid ? fifo_data[rd_ptr] : '0;
    assign desc_last  = desc_valid ? fifo_last[rd_ptr] : 1'b0;
    assign desc_meta  = desc_valid ? fifo_meta[rd_ptr] : 24'h0;

endmodule

// File: tb/tb_seed_bit_pack.sv
// Bench for seed_bit_pack: directed keypoint streams, a queue-based reference of the word stream and
// output buffer checked every cycle, plus literal expectations for the documented scenarios.
module tb_seed_bit_pack;

    localparam int NS  = 249;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_addr1 = 0, valid_addr2 = 0, valid_addr3 = 0, valid_addr4 = 0;
    logic [7:0]  pix_in = 0, center_pix = 0;
    logic [31:0] desc_data;
    logic        desc_last;
    logic [23:0] desc_meta;
    logic        desc_valid;
    logic        desc_ready = 1'b1;
    logic        kp_done;
    logic        overflow;

    seed_bit_pack dut (
        .clk(clk), .rst(rst),
        .valid_addr1(valid_addr1), .valid_addr2(valid_addr2),
        .valid_addr3(valid_addr3), .valid_addr4(valid_addr4),
        .pix_in(pix_in), .center_pix(center_pix),
        .desc_data(desc_data), .desc_last(desc_last), .desc_meta(desc_meta),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .kp_done(kp_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v1, v2, v3, v4;
        bit [7:0] pix, ctr;
    } ent_t;

    typedef struct {
        bit [31:0] data;
        bit        last;
        bit [23:0] meta;
    } word_t;

    int checks = 0;
    int errors = 0;

    ent_t  pipe[$];
    word_t mq[$];
    word_t log_q[$];
    bit    m_ovf;
    bit    m_kp_done;
    bit    kp_bits [NS];
    int    kp_n;
    int    c2, c3, c4;
    bit [7:0] kp_ctr;
    int    dut_acc;
    int    dut_kp_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic ent_t mk(bit v1, bit v2, bit v3, bit v4, bit [7:0] pix, bit [7:0] ctr);
        ent_t e;
        e.v1 = v1; e.v2 = v2; e.v3 = v3; e.v4 = v4; e.pix = pix; e.ctr = ctr;
        return e;
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_ovf = 0;
        m_kp_done = 0;
        kp_n = 0;
        c2 = 0; c3 = 0; c4 = 0;
        pipe.delete();
        for (int i = 0; i < LAT; i++) pipe.push_back(mk(0, 0, 0, 0, 8'd0, 8'd0));
    endfunction

    // One clock edge of the reference: pop first, then the sample arriving from memory.
    function automatic void model_step(ent_t m, bit rdy);
        word_t w;
        int    base;
        m_kp_done = 0;
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        if (!m.v1) return;
        if (kp_n == 0) kp_ctr = m.ctr;
        kp_bits[kp_n] = (m.pix > kp_ctr);
        if (m.v2 && c2 < 255) c2++;
        if (m.v3 && c3 < 255) c3++;
        if (m.v4 && c4 < 255) c4++;
        kp_n++;
        if (kp_n % 32 == 0 || kp_n == NS) begin
            base = ((kp_n - 1) / 32) * 32;
            w.data = 0;
            for (int i = base; i < kp_n; i++) w.data[i - base] = kp_bits[i];
            w.last = (kp_n == NS);
            w.meta = w.last ? {c4[7:0], c3[7:0], c2[7:0]} : 24'h0;
            log_q.push_back(w);
            if (mq.size() < 2) mq.push_back(w);
            else m_ovf = 1;
            if (w.last) begin
                m_kp_done = 1;
                kp_n = 0;
                c2 = 0; c3 = 0; c4 = 0;
            end
        end
    endfunction

    task automatic compare_outputs();
        word_t h;
        h.data = 0; h.last = 0; h.meta = 0;
        if (mq.size() > 0) h = mq[0];
        check("desc_valid", desc_valid, mq.size() > 0);
        check("desc_data", desc_data, h.data);
        check("desc_last", desc_last, h.last);
        check("desc_meta", desc_meta, h.meta);
        check("kp_done", kp_done, m_kp_done);
        check("overflow", overflow, m_ovf);
        if (kp_done) dut_kp_done++;
    endtask

    task automatic cycle(input ent_t e);
        ent_t m;
        m = pipe.pop_front();
        pipe.push_back(e);
        valid_addr1 = e.v1; valid_addr2 = e.v2; valid_addr3 = e.v3; valid_addr4 = e.v4;
        pix_in = m.pix;
        center_pix = m.ctr;
        #2;
        if (desc_valid && desc_ready) dut_acc++;
        @(posedge clk);
        model_step(m, desc_ready);
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(mk(0, 0, 0, 0, 8'd0, 8'd0));
    endtask

    task automatic run_kp(input bit [7:0] ctr, input bit [7:0] pa, input bit [7:0] pb,
                          input int r2, input int r3, input int gap_every, input int stop_at);
        for (int s = 0; s < stop_at; s++) begin
            if (gap_every > 0 && s > 0 && s % gap_every == 0) idle(3);
            cycle(mk(1, s < r2, s < r3, 0, (s % 2) ? pb : pa, ctr));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        valid_addr1 = 0; valid_addr2 = 0; valid_addr3 = 0; valid_addr4 = 0;
        #1;
        check("rst_valid", desc_valid, 1'b0);
        check("rst_data", desc_data, 32'h0);
        check("rst_kp_done", kp_done, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
    endtask

    int base;

    initial begin
        model_clear();
        log_q.delete();
        dut_acc = 0;
        dut_kp_done = 0;
        #1;
        check("reset_valid", desc_valid, 1'b0);
        check("reset_meta", desc_meta, 24'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // 1: all samples above centre
        base = log_q.size();
        run_kp(8'd100, 8'd150, 8'd150, 0, 0, 0, NS);
        idle(4);
        check("t1_words", log_q.size() - base, 8);
        check("t1_w0", log_q[base].data, 32'hFFFF_FFFF);
        check("t1_w6", log_q[base + 6].data, 32'hFFFF_FFFF);
        check("t1_last", log_q[base + 7].data, 32'h01FF_FFFF);
        check("t1_last_flag", log_q[base + 7].last, 1'b1);
        check("t1_dut_acc", dut_acc, 8);
        check("t1_kp_done_cnt", dut_kp_done, 1);
        check("t1_overflow", overflow, 1'b0);

        // 2: equality must give 0
        base = log_q.size();
        run_kp(8'd100, 8'd100, 8'd101, 0, 0, 0, NS);
        idle(4);
        check("t2_w0", log_q[base].data, 32'hAAAA_AAAA);
        check("t2_last", log_q[base + 7].data, 32'h00AA_AAAA);

        // 3: consumer stalled for a whole keypoint
        dut_acc = 0;
        desc_ready = 1'b0;
        run_kp(8'd100, 8'd150, 8'd150, 0, 0, 0, NS);
        idle(4);
        check("t3_overflow", overflow, 1'b1);
        check("t3_valid", desc_valid, 1'b1);
        check("t3_head", desc_data, 32'hFFFF_FFFF);
        desc_ready = 1'b1;
        idle(6);
        check("t3_drained", dut_acc, 2);
        check("t3_empty", desc_valid, 1'b0);
        do_reset();

        // 4: ring counts
        base = log_q.size();
        run_kp(8'd100, 8'd150, 8'd150, 10, 5, 0, NS);
        idle(4);
        check("t4_meta_last", log_q[base + 7].meta, 24'h00_05_0A);
        check("t4_meta_mid", log_q[base + 3].meta, 24'h0);

        // 5: gaps and two keypoints with different centres
        base = log_q.size();
        dut_acc = 0;
        run_kp(8'd100, 8'd150, 8'd150, 0, 0, 50, NS);
        run_kp(8'd200, 8'd150, 8'd150, 0, 0, 50, NS);
        idle(4);
        check("t5_words", dut_acc, 16);
        check("t5_kp0_w2", log_q[base + 2].data, 32'hFFFF_FFFF);
        check("t5_kp1_w0", log_q[base + 8].data, 32'h0);
        check("t5_kp1_last", log_q[base + 15].data, 32'h0);

        // 6: reset in the middle of a keypoint, then a clean all-zero keypoint
        run_kp(8'd100, 8'd150, 8'd150, 0, 0, 0, 120);
        do_reset();
        base = log_q.size();
        dut_acc = 0;
        run_kp(8'd100, 8'd50, 8'd50, 0, 0, 0, NS);
        idle(4);
        check("t6_words", dut_acc, 8);
        check("t6_w0", log_q[base].data, 32'h0);
        check("t6_last", log_q[base + 7].last, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
